sync_detector: RTL

- Receive-side partner of the sine stimulus generator in the acquisition chain.
- Consumes the generator's start_conv, new_period and phaze strobes, and drives a one-cycle convert-start to the external ADC.
- Captures each ADC result and forms a per-period synchronous (lock-in) sum: the sample is added while phaze=1 and subtracted while phaze=0.
- Publishes one signed result per stimulus period, with sticky error flags for conversion timeout and overrun.

---
 rtl/sync_det_pkg.sv | 19 +
 rtl/rise_detect.sv | 19 +
 rtl/sync_detector.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sync_det_pkg.sv
// Shared types and constants for the synchronous (lock-in) detector.
// Imported by sync_detector; the state enum and count limits live here.
package sync_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

    // Offset-binary midscale for an ADC of the given width.
    function automatic logic [31:0] midscale(input int adc_w);
        return 32'd1 << (adc_w - 1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-register rising-edge detector; rise is high in the cycle where sig
// is 1 and its registered copy is still 0.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/sync_detector.sv
// Lock-in detector: starts ADC conversions on generator strobes, sums samples
// signed by stimulus phase and publishes one result per stimulus period.
module sync_detector
    import sync_det_pkg::*;
#(
    parameter int ADC_W   = 10,
    parameter int ACC_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    start_conv,
    input  logic                    new_period,
    input  logic                    phaze,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic                    adc_ready,
    output logic                    adc_convst,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    output logic [CNT_W-1:0]        conv_count,
    output logic                    err_timeout,
    output logic                    err_overrun,
    input  logic                    err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic signed [ACC_W-1:0] MID = ACC_W'(midscale(ADC_W));

    state_t state, next_state;
    logic sc_rise, np_rise;
    logic start, timeout_evt, overrun_evt;
    logic ph_r;
    logic [TMO_W-1:0] tmo_cnt;
    logic [ADC_W-1:0] sample;
    logic signed [ACC_W-1:0] acc, term;
    logic [CNT_W-1:0] cnt;

    rise_detect u_sc_rise (.clk(clk), .rst(rst), .sig(start_conv), .rise(sc_rise));
    rise_detect u_np_rise (.clk(clk), .rst(rst), .sig(new_period), .rise(np_rise));

    assign busy        = (state != IDLE);
    assign overrun_evt = sc_rise & busy;
    assign term        = ACC_W'(sample) - MID;

    always_comb begin
        next_state  = state;
        start       = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (sc_rise && enable) begin
                    start      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                // A sample arriving on the limit cycle still wins.
                if (adc_ready) begin
                    next_state = ACCUM;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    next_state  = IDLE;
                end
            end
            ACCUM:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_convst   <= 1'b0;
            ph_r         <= 1'b0;
            tmo_cnt      <= '0;
            sample       <= '0;
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            conv_count   <= '0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            adc_convst   <= start;
            result_valid <= 1'b0;

            if (start) begin
                ph_r    <= phaze;
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == WAIT && adc_ready) sample <= adc_data;

            // A sample accumulated on the period boundary opens the new period.
            if (np_rise) begin
                if (cnt != '0) begin
                    result       <= acc;
                    conv_count   <= cnt;
                    result_valid <= 1'b1;
                end
                if (state == ACCUM) begin
                    acc <= ph_r ? term : -term;
                    cnt <= CNT_W'(1);
                end else begin
                    acc <= '0;
                    cnt <= '0;
                end
            end else if (state == ACCUM) begin
                acc <= ph_r ? acc + term : acc - term;
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end

            if (err_clr) begin
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end
            if (timeout_evt) err_timeout <= 1'b1;
            if (overrun_evt) err_overrun <= 1'b1;
        end
    end

endmodule
